// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter between instruction fetch and MEM-stage loads/stores.
// MEM has priority; each grant waits for ram_ack or aborts after ACK_TIMEOUT cycles.
module mem_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [5:0]  stall,
  output logic        err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic          ram_ce_q, ram_ce_d, ram_we_q, ram_we_d;
  logic [31:0]   ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
  logic [3:0]    ram_sel_q, ram_sel_d;
  logic [31:0]   if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic          if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic          err_q, err_d, discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin, drop;
  logic [31:0]   rdv;

  always_comb begin
    state_d     = state_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_sel_d   = ram_sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = err_q;
    discard_d   = discard_q;
    cnt_d       = cnt_q;
    fin         = 1'b0;
    drop        = 1'b0;
    rdv         = '0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        // A done pulse still on the outputs forces one turnaround cycle.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            state_d     = MEM_WAIT;
            ram_ce_d    = 1'b1;
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            ram_sel_d   = mem_sel;
            cnt_d       = '0;
          end else if (if_req && !flush) begin
            state_d     = IF_WAIT;
            ram_ce_d    = 1'b1;
            ram_we_d    = 1'b0;
            ram_addr_d  = if_addr;
            ram_wdata_d = '0;
            ram_sel_d   = 4'hF;
            cnt_d       = '0;
          end
        end
      end
      IF_WAIT, MEM_WAIT: begin
        fin  = ram_ack || (cnt_q == CW'(ACK_TIMEOUT - 1));
        drop = (state_q == IF_WAIT) && (discard_q || flush);
        rdv  = ram_ack ? ram_rdata : 32'h0;
        if (state_q == IF_WAIT && flush) discard_d = 1'b1;
        if (fin) begin
          state_d   = IDLE;
          ram_ce_d  = 1'b0;
          ram_we_d  = 1'b0;
          discard_d = 1'b0;
          err_d     = err_q | ~ram_ack;
          if (state_q == MEM_WAIT) begin
            mem_rdata_d = rdv;
            mem_done_d  = 1'b1;
          end else if (!drop) begin
            if_rdata_d = rdv;
            if_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_sel_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    if (mem_req && !mem_done_q)                stall = 6'b011111;
    else if (if_req && !if_done_q && !flush)   stall = 6'b000011;
    else                                       stall = 6'b000000;
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_sel   = ram_sel_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic against a
// transaction-level model of the shared port (owner, age, discard, results).
module tb_mem_arbiter;
  localparam int T = 16;

  logic        clk, rst;
  logic        if_req, flush, mem_req, mem_we, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_done, mem_done, ram_ce, ram_we, err;
  logic [3:0]  ram_sel;
  logic [5:0]  stall;

  mem_arbiter #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port, how long it has waited, and results.
  int          m_own;   // 0 none, 1 fetch, 2 data
  int          m_age;
  bit          m_drop, m_we, m_ifdone, m_memdone, m_err;
  logic [31:0] m_addr, m_wdata, m_ifd, m_memd;
  logic [3:0]  m_sel;

  task automatic model_reset();
    m_own = 0; m_age = 0; m_drop = 0; m_we = 0; m_ifdone = 0; m_memdone = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_ifd = 0; m_memd = 0; m_sel = 0;
  endtask

  task automatic model_edge();
    bit pend, done;
    logic [31:0] v;
    pend = m_ifdone || m_memdone;
    m_ifdone = 0; m_memdone = 0;
    done = 0; v = 0;
    if (m_own == 0) begin
      if (!pend && mem_req) begin
        m_own = 2; m_age = 0; m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; m_sel = mem_sel;
      end else if (!pend && if_req && !flush) begin
        m_own = 1; m_age = 0; m_addr = if_addr; m_we = 0; m_wdata = 0; m_sel = 4'hF;
      end
    end else begin
      if (m_own == 1 && flush) m_drop = 1;
      if (ram_ack) begin
        done = 1; v = ram_rdata;
      end else begin
        m_age++;
        if (m_age == T) begin done = 1; v = 0; m_err = 1; end
      end
      if (done) begin
        if (m_own == 2) begin m_memdone = 1; m_memd = v; end
        else if (!m_drop) begin m_ifdone = 1; m_ifd = v; end
        m_own = 0; m_drop = 0; m_we = 0;
      end
    end
  endtask

  task automatic step();
    logic [5:0] es;
    #1;
    if (mem_req && !m_memdone)                es = 6'b011111;
    else if (if_req && !m_ifdone && !flush)   es = 6'b000011;
    else                                      es = 6'b000000;
    chk("stall", {26'h0, stall}, {26'h0, es});
    @(posedge clk);
    model_edge();
    #1;
    chk("ram_ce", {31'h0, ram_ce}, {31'h0, m_own != 0});
    if (m_own != 0) begin
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_we", {31'h0, ram_we}, {31'h0, m_we});
      chk("ram_sel", {28'h0, ram_sel}, {28'h0, m_sel});
      chk("ram_wdata", ram_wdata, m_wdata);
    end
    chk("if_done", {31'h0, if_done}, {31'h0, m_ifdone});
    chk("mem_done", {31'h0, mem_done}, {31'h0, m_memdone});
    chk("if_rdata", if_rdata, m_ifd);
    chk("mem_rdata", mem_rdata, m_memd);
    chk("err", {31'h0, err}, {31'h0, m_err});
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_ifdone || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      flush = if_req && ($urandom_range(0, 9) == 0);
      if (flush) if_addr = $urandom;
      if (m_memdone || !mem_req) begin
        mem_req = ($urandom_range(0, 3) == 0);
        mem_we = $urandom_range(0, 1);
        mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
      end
      ram_ack = ((i / 150) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      ram_rdata = $urandom;
      step();
    end
  endtask

  initial begin
    rst = 1; if_req = 0; flush = 0; mem_req = 0; mem_we = 0; ram_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; ram_rdata = 0; mem_sel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst ram_ce", {31'h0, ram_ce}, 32'h0);
    chk("rst ram_addr", ram_addr, 32'h0);
    chk("rst ram_sel", {28'h0, ram_sel}, 32'h0);
    chk("rst rdata", if_rdata | mem_rdata, 32'h0);
    chk("rst flags", {28'h0, if_done, mem_done, err, ram_we}, 32'h0);
    rst = 0;

    // Fetch with ack two cycles after ram_ce.
    if_req = 1; if_addr = 32'h100;
    step();
    chk("fetch addr", ram_addr, 32'h100);
    chk("fetch stall", {26'h0, stall}, 32'h3);
    step();
    ram_ack = 1; ram_rdata = 32'h13;
    step();
    chk("fetch rdata", if_rdata, 32'h13);
    if_req = 0; ram_ack = 0;
    step(); step();

    // Simultaneous requests: data first, one idle turnaround, then fetch.
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_sel = 4'hF;
    if_req = 1; if_addr = 32'h104;
    step();
    chk("prio we", {31'h0, ram_we}, 32'h1);
    ram_ack = 1;
    step();
    chk("store done", {31'h0, mem_done}, 32'h1);
    mem_req = 0; ram_ack = 0;
    step();
    chk("turnaround", {31'h0, ram_ce}, 32'h0);
    step();
    chk("fetch after", ram_addr, 32'h104);
    ram_ack = 1;
    step();
    if_req = 0; ram_ack = 0;
    step();

    // Flush during fetch wait, ack afterwards: result dropped, new target fetched.
    if_req = 1; if_addr = 32'h200;
    step();
    flush = 1; if_addr = 32'h300;
    step();
    flush = 0; ram_ack = 1; ram_rdata = 32'h55;
    step();
    chk("flush drop", {31'h0, if_done}, 32'h0);
    ram_ack = 0;
    step();
    chk("refetch", ram_addr, 32'h300);
    ram_ack = 1; step();
    if_req = 0; ram_ack = 0; step();

    // Load never acknowledged: timeout.
    mem_req = 1; mem_we = 0; mem_addr = 32'h40; mem_sel = 4'h3;
    for (int i = 0; i < T + 1; i++) begin
      step();
      if (m_memdone) mem_req = 0;
    end
    chk("timeout err", {31'h0, err}, 32'h1);
    chk("timeout rdata", mem_rdata, 32'h0);
    mem_req = 0;
    step();

    rand_traffic(1500);

    // Reset mid data access.
    if_req = 0; flush = 0; ram_ack = 0;
    while (m_own != 0 || m_ifdone || m_memdone) step();
    mem_req = 1; mem_we = 0; mem_addr = 32'h80;
    step();
    #2 rst = 1;
    #1;
    chk("async rst ce", {31'h0, ram_ce}, 32'h0);
    chk("async rst err", {31'h0, err}, 32'h0);
    model_reset();
    mem_req = 0;
    @(posedge clk);
    #1 rst = 0;
    ram_ack = 1;
    for (int i = 0; i < 4; i++) step();
    ram_ack = 0;

    rand_traffic(500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, max cycles a granted access waits for ram_ack before abort.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  fetch request; held until if_done.
REQ-005 if_addr  in  32  fetch word address.
REQ-006 if_rdata  out  32  fetched instruction; valid while if_done=1.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 flush  in  1  branch/jump flush; cancels current fetch.
REQ-009 mem_req  in  1  load/store request from MEM stage; held until mem_done.
REQ-010 mem_we  in  1  1=store, 0=load.
REQ-011 mem_addr  in  32  data address.
REQ-012 mem_wdata  in  32  store data.
REQ-013 mem_sel  in  4  byte enables.
REQ-014 mem_rdata  out  32  load data; valid while mem_done=1.
REQ-015 mem_done  out  1  one-cycle data completion pulse.
REQ-016 ram_ce, ram_we  out  1 each  shared-port enable and write strobe.
REQ-017 ram_addr, ram_wdata  out  32 each; ram_sel  out  4  shared-port address, data, byte enables.
REQ-018 ram_rdata  in  32; ram_ack  in  1  port read data and completion, sampled only while ram_ce=1.
REQ-019 stall  out  6  pipeline hold vector: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 States IDLE, IF_WAIT, MEM_WAIT; all ram_*, *_rdata, *_done, err registered.
REQ-022 IDLE, mem_req=1: latch mem_* onto ram_*, ram_ce=1, ram_we=mem_we, go MEM_WAIT; MEM wins over simultaneous if_req.
REQ-023 IDLE, mem_req=0, if_req=1, flush=0: ram_addr=if_addr, ram_sel=4'hF, ram_we=0, ram_ce=1, go IF_WAIT.
REQ-024 IDLE never grants in a cycle where if_done or mem_done is 1 (one-cycle turnaround).
REQ-025 WAIT state, ram_ack=1: next edge ram_ce=0, ram_we=0, capture ram_rdata into owner's rdata, owner's done=1 for exactly one cycle, go IDLE.
REQ-026 Minimum latency: req sampled edge N, ram_ce high after N, ack sampled edge N+1, done high after N+1.
REQ-027 ram_* outputs constant throughout a WAIT state.
REQ-028 Wait counter clears on grant, increments each WAIT cycle without ack; at ACK_TIMEOUT: ram_ce=0, owner's done pulses with rdata=0, err=1, go IDLE.
REQ-029 flush=1 in IF_WAIT sets discard flag; access completes normally but if_done stays 0; flag clears on return to IDLE.
REQ-030 flush and ram_ack in the same IF_WAIT cycle: if_done suppressed.
REQ-031 flush has no effect on MEM_WAIT.
REQ-032 stall (combinational): mem_req=1 and mem_done=0 -> 6'b011111; else if_req=1, if_done=0, flush=0 -> 6'b000011; else 6'b000000.
REQ-033 rdata outputs hold last captured value between done pulses.

Reset
REQ-034 rst=1 immediately forces state IDLE, ram_ce=0, ram_we=0, ram_addr/ram_wdata=0, ram_sel=0, if_rdata/mem_rdata=0, if_done/mem_done=0, err=0, counter and discard flag 0.
REQ-035 Reset mid-access aborts it; no done pulse follows reset release.

Verification
REQ-036 if_req, if_addr=0x100, ack 2 cycles after ram_ce, ram_rdata=0x00000013 -> ram_addr=0x100, ram_sel=F, one if_done with if_rdata=0x13, stall=000011 until done.
REQ-037 mem_req and if_req same cycle, store 0xDEADBEEF to 0x2000 sel=F -> MEM granted first (ram_we=1), mem_done, one idle turnaround, then IF granted.
REQ-038 flush during IF_WAIT, then ack -> no if_done; next IDLE grants new if_addr.
REQ-039 Load with ram_ack never asserted, ACK_TIMEOUT=16 -> after 16 wait cycles ram_ce=0, mem_done pulse, mem_rdata=0, err=1 until rst.
REQ-040 rst asserted in MEM_WAIT between clock edges -> ram_ce=0 immediately; no mem_done after release.
